pingpong_bank_sched: RTL and testbench

Single-clock scheduler for a two-bank (ping/pong) line buffer built from two external simple dual-port RAMs. It sequences writes of fixed-length lines into alternating banks and reads whole lines back out in write order. It generates RAM enables and addresses plus an output-mux select and valid aligned to RAM read latency. It sits on the tx side of the HDMI pixel path, between the line source and the pixel output stage.

---
 rtl/pingpong_bank_sched.sv | 94 +++++++++
 tb/tb_pingpong_bank_sched.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pingpong_bank_sched.sv
// pingpong_bank_sched: two-bank line-buffer scheduler for RAM enables, addresses and the latency-aligned output mux.
// PINGPONG_DROP_CNT_EN builds the saturating rejected-offer counter; without it drop_cnt is tied to 0.
module pingpong_bank_sched #(
  parameter int LINE_LEN = 80,
  parameter int ADDR_W   = 7,
  parameter int RD_LAT   = 1
) (
  input  logic              tx_clk,
  input  logic              tx_rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [1:0]        wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic              rd_req,
  output logic [1:0]        rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              out_valid,
  output logic              out_sel,
  output logic              out_last,
  output logic [3:0]        bank_state,
  output logic              line_done,
  output logic [15:0]       drop_cnt
);
  typedef enum logic [1:0] {FREE, FILLING, FULL, DRAINING} bank_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LINE_LEN - 1);
  bank_t st_q [2];
  bank_t st_d [2];
  logic wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d, line_done_q, line_done_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [1:0] ov_q, ov_d, os_q, os_d, ol_q, ol_d;
  logic wr_acc, wr_last, rd_go, rd_last;
  always_comb begin
    wr_ready = tx_rst_n & (st_q[wr_bank_q] == FREE || st_q[wr_bank_q] == FILLING);
    wr_acc = wr_valid & wr_ready;
    wr_last = wr_acc & (wr_cnt_q == LAST);
    wr_en = {wr_acc & wr_bank_q, wr_acc & ~wr_bank_q};
    wr_addr = wr_cnt_q;
    rd_go = tx_rst_n & rd_req & (st_q[rd_bank_q] == FULL || st_q[rd_bank_q] == DRAINING);
    rd_last = rd_go & (rd_cnt_q == LAST);
    rd_en = {rd_go & rd_bank_q, rd_go & ~rd_bank_q};
    rd_addr = rd_cnt_q;
    wr_cnt_d = wr_last ? '0 : wr_cnt_q + ADDR_W'(wr_acc);
    wr_bank_d = wr_bank_q ^ wr_last;
    rd_cnt_d = rd_last ? '0 : rd_cnt_q + ADDR_W'(rd_go);
    rd_bank_d = rd_bank_q ^ rd_last;
    line_done_d = wr_last;
    // a bank is never written and read in the same cycle, so the two updates cannot collide
    for (int b = 0; b < 2; b++)
      st_d[b] = wr_en[b] ? (wr_last ? FULL : FILLING) :
                rd_en[b] ? (rd_last ? FREE : DRAINING) : st_q[b];
    ov_d = {ov_q[0], rd_go};
    os_d = {os_q[0], rd_bank_q};
    ol_d = {ol_q[0], rd_last};
  end
  always_ff @(posedge tx_clk) begin
    if (!tx_rst_n) begin
      st_q <= '{FREE, FREE};
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      line_done_q <= 1'b0;
      ov_q <= '0;
      os_q <= '0;
      ol_q <= '0;
    end else begin
      st_q <= st_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      line_done_q <= line_done_d;
      ov_q <= ov_d;
      os_q <= os_d;
      ol_q <= ol_d;
    end
  end
  assign out_valid = (RD_LAT == 1) ? ov_q[0] : ov_q[1];
  assign out_sel = (RD_LAT == 1) ? os_q[0] : os_q[1];
  assign out_last = (RD_LAT == 1) ? ol_q[0] : ol_q[1];
  assign bank_state = {st_q[1], st_q[0]};
  assign line_done = line_done_q;
`ifdef PINGPONG_DROP_CNT_EN
  logic [15:0] drop_q, drop_d;
  always_comb drop_d = (tx_rst_n & wr_valid & ~wr_ready & ~&drop_q) ? drop_q + 16'd1 : drop_q;
  always_ff @(posedge tx_clk) begin
    if (!tx_rst_n) drop_q <= '0;
    else drop_q <= drop_d;
  end
  assign drop_cnt = drop_q;
`else
  assign drop_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_pingpong_bank_sched.sv
// tb_pingpong_bank_sched: vector table plus randomized traffic against a fill/drain-count model of the scheduler.
module tb_pingpong_bank_sched;
  localparam int L = 80;
  localparam int AW = 7;
`ifdef PINGPONG_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0, wv = 1'b0, rr = 1'b0;
  logic wr_ready, line_done, ov_a, os_a, ol_a;
  logic [1:0] wr_en, rd_en;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [3:0] bank_state;
  logic [15:0] drop_cnt;
  logic wr_ready_b, line_done_b, ov_b, os_b, ol_b;
  logic [1:0] wr_en_b, rd_en_b;
  logic [AW-1:0] wr_addr_b, rd_addr_b;
  logic [3:0] bank_state_b;
  logic [15:0] drop_cnt_b;

  pingpong_bank_sched #(.LINE_LEN(L), .ADDR_W(AW), .RD_LAT(1)) dut_a (
    .tx_clk(clk), .tx_rst_n(rst_n), .wr_valid(wv), .wr_ready(wr_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .rd_req(rr), .rd_en(rd_en), .rd_addr(rd_addr), .out_valid(ov_a),
    .out_sel(os_a), .out_last(ol_a), .bank_state(bank_state), .line_done(line_done),
    .drop_cnt(drop_cnt));
  pingpong_bank_sched #(.LINE_LEN(L), .ADDR_W(AW), .RD_LAT(2)) dut_b (
    .tx_clk(clk), .tx_rst_n(rst_n), .wr_valid(wv), .wr_ready(wr_ready_b), .wr_en(wr_en_b),
    .wr_addr(wr_addr_b), .rd_req(rr), .rd_en(rd_en_b), .rd_addr(rd_addr_b), .out_valid(ov_b),
    .out_sel(os_b), .out_last(ol_b), .bank_state(bank_state_b), .line_done(line_done_b),
    .drop_cnt(drop_cnt_b));

  int nchk = 0, npass = 0;
  int fill [2];
  int rdn [2];
  bit wb, rb, ld;
  int drop;
  bit [2:0] pipe1 [$];
  bit [2:0] pipe2 [$];
  int tag [2][L];
  int sent [$];
  int wid = 0;

  task automatic chk(string nm, int act, int exp);
    nchk++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  function automatic int st_of(int b);
    return fill[b] == 0 ? 0 : fill[b] < L ? 1 : rdn[b] == 0 ? 2 : 3;
  endfunction

  task automatic model_reset();
    fill = '{0, 0};
    rdn = '{0, 0};
    wb = 0;
    rb = 0;
    ld = 0;
    drop = 0;
    pipe1 = '{3'b0};
    pipe2 = '{3'b0, 3'b0};
    sent.delete();
  endtask

  task automatic cycle();
    bit e_rdy, e_acc, e_rd, e_last;
    @(negedge clk);
    e_rdy = rst_n && fill[wb] < L;
    e_acc = e_rdy && wv;
    e_rd = rst_n && rr && fill[rb] == L;
    e_last = e_rd && rdn[rb] == L - 1;
    chk("wr_ready", wr_ready, e_rdy);
    chk("wr_en", wr_en, e_acc ? (wb ? 2 : 1) : 0);
    if (e_acc) chk("wr_addr", wr_addr, fill[wb]);
    chk("rd_en", rd_en, e_rd ? (rb ? 2 : 1) : 0);
    if (e_rd) chk("rd_addr", rd_addr, rdn[rb]);
    chk("out_valid_lat1", ov_a, pipe1[0][2]);
    if (pipe1[0][2]) begin
      chk("out_sel_lat1", os_a, pipe1[0][1]);
      chk("out_last_lat1", ol_a, pipe1[0][0]);
    end
    chk("out_valid_lat2", ov_b, pipe2[0][2]);
    if (pipe2[0][2]) begin
      chk("out_sel_lat2", os_b, pipe2[0][1]);
      chk("out_last_lat2", ol_b, pipe2[0][0]);
    end
    chk("bank_state", bank_state, st_of(1) * 4 + st_of(0));
    chk("line_done", line_done, ld);
    chk("drop_cnt", drop_cnt, DROP_EN ? drop : 0);
    if (wr_en != 0 && wr_addr < L) begin
      tag[wr_en[1]][wr_addr] = wid;
      sent.push_back(wid);
      wid++;
    end
    if (rd_en != 0) begin
      chk("read_has_line", sent.size() > 0, 1);
      if (sent.size() > 0 && rd_addr < L) chk("read_order", tag[rd_en[1]][rd_addr], sent.pop_front());
    end
    if (!rst_n) model_reset();
    else begin
      pipe1.push_back({e_rd, rb, e_last});
      void'(pipe1.pop_front());
      pipe2.push_back({e_rd, rb, e_last});
      void'(pipe2.pop_front());
      if (wv && !e_rdy && drop < 65535) drop++;
      ld = e_acc && fill[wb] == L - 1;
      if (e_acc) begin
        fill[wb]++;
        if (fill[wb] == L) wb = !wb;
      end
      if (e_rd) begin
        rdn[rb]++;
        if (rdn[rb] == L) begin
          fill[rb] = 0;
          rdn[rb] = 0;
          rb = !rb;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit rst_n, wv, rr;
    int n;
    logic [3:0] bs;
    bit ld, ov;
    int drop;
  } vec_t;
  vec_t tbl [17];

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 2,     4'b0000, 1'b0, 1'b0, 0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1,     4'b0001, 1'b0, 1'b0, 0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 79,    4'b0010, 1'b1, 1'b0, 0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1,     4'b0011, 1'b0, 1'b1, 0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 79,    4'b0000, 1'b0, 1'b1, 0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 160,   4'b1010, 1'b1, 1'b0, 0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 80,    4'b1010, 1'b0, 1'b0, 80};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1,     4'b0000, 1'b0, 1'b0, 0};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 5,     4'b0000, 1'b0, 1'b0, 0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 40,    4'b0001, 1'b0, 1'b0, 0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 45,    4'b0110, 1'b0, 1'b0, 0};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 400,   4'b1000, 1'b1, 1'b1, 5};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 30,    4'b1100, 1'b0, 1'b1, 5};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1,     4'b0000, 1'b0, 1'b0, 0};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 1,     4'b0001, 1'b0, 1'b0, 0};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 159,   4'b1010, 1'b1, 1'b0, 0};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 66000, 4'b1010, 1'b0, 1'b0, 65535};
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    for (int i = 0; i < 17; i++) begin
      rst_n = tbl[i].rst_n;
      wv = tbl[i].wv;
      rr = tbl[i].rr;
      repeat (tbl[i].n) cycle();
      chk($sformatf("vec%0d_bank_state", i), bank_state, tbl[i].bs);
      chk($sformatf("vec%0d_line_done", i), line_done, tbl[i].ld);
      chk($sformatf("vec%0d_out_valid", i), ov_a, tbl[i].ov);
      chk($sformatf("vec%0d_drop_cnt", i), drop_cnt, DROP_EN ? tbl[i].drop : 0);
    end
    for (int i = 0; i < 3000; i++) begin
      rst_n = $urandom_range(0, 299) != 0;
      wv = $urandom_range(0, 3) != 0;
      rr = $urandom_range(0, 2) != 0;
      cycle();
    end
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
